// File: rtl/parking_exit_gate_if.sv
// Exit-side bus: exit sensor / pay terminal inputs and allocator-facing outputs.
interface parking_exit_gate_if #(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned SLOT_W    = 2,
    parameter int unsigned FEE_W     = 12
);
    logic                 park_valid;
    logic [SLOT_W-1:0]    park_slot;
    logic                 exit_req;
    logic [SLOT_W-1:0]    exit_slot;
    logic                 pay_ok;
    logic [FEE_W-1:0]     fee;
    logic                 fee_valid;
    logic                 gate_open;
    logic                 release_valid;
    logic [SLOT_W-1:0]    release_slot;
    logic                 error;
    logic [NUM_SLOTS-1:0] occupied;
    logic [2:0]           state;

    modport master (
        output park_valid, park_slot, exit_req, exit_slot, pay_ok,
        input  fee, fee_valid, gate_open, release_valid, release_slot, error, occupied, state
    );

    modport slave (
        input  park_valid, park_slot, exit_req, exit_slot, pay_ok,
        output fee, fee_valid, gate_open, release_valid, release_slot, error, occupied, state
    );
endinterface

// File: rtl/parking_exit_gate.sv
// Parking exit controller: tracks occupancy and parked time, quotes a fee, waits for payment,
// opens the gate and reports the freed slot back to the allocator.
module parking_exit_gate #(
    parameter int unsigned NUM_SLOTS   = 4,
    parameter int unsigned SLOT_W      = 2,
    parameter int unsigned TICK_DIV    = 4,
    parameter int unsigned TIME_W      = 8,
    parameter int unsigned RATE        = 3,
    parameter int unsigned FEE_W       = 12,
    parameter int unsigned GATE_CYCLES = 10,
    parameter int unsigned PAY_TIMEOUT = 50
) (
    input logic                clk,
    input logic                reset,
    parking_exit_gate_if.slave bus
);
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StCheck   = 3'd1,
        StWaitPay = 3'd2,
        StOpen    = 3'd3,
        StWaitClr = 3'd4
    } state_e;

    localparam int unsigned PresW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CntMax = (GATE_CYCLES > PAY_TIMEOUT) ? GATE_CYCLES : PAY_TIMEOUT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned ProdW  = TIME_W + 32;

    state_e               state_q, state_d;
    logic [SLOT_W-1:0]    slot_q;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [PresW-1:0]     pres_q;
    logic [NUM_SLOTS-1:0] occupied_q, occupied_d;
    logic [TIME_W-1:0]    timer_q [NUM_SLOTS];
    logic [TIME_W-1:0]    timer_d [NUM_SLOTS];
    logic [FEE_W-1:0]     fee_q;
    logic                 error_q, rel_valid_q;
    logic [SLOT_W-1:0]    rel_slot_q;

    logic              tick, park_ok, park_bad, check_ok, check_bad, pay_edge, timeout;
    logic [TIME_W-1:0] t_eff;
    logic [ProdW-1:0]  prod;
    logic [FEE_W-1:0]  quote;

    assign tick      = (pres_q == PresW'(TICK_DIV - 1));
    assign park_ok   = bus.park_valid && !occupied_q[bus.park_slot];
    assign park_bad  = bus.park_valid && occupied_q[bus.park_slot];
    assign check_ok  = (state_q == StCheck) && occupied_q[slot_q];
    assign check_bad = (state_q == StCheck) && !occupied_q[slot_q];
    assign pay_edge  = (state_q == StWaitPay) && bus.pay_ok;
    assign timeout   = (state_q == StWaitPay) && !bus.pay_ok &&
                       (cnt_q == CntW'(PAY_TIMEOUT - 1));

    // A car that has not yet seen a tick is still billed one unit.
    assign t_eff = (timer_q[slot_q] == '0) ? TIME_W'(1) : timer_q[slot_q];
    assign prod  = ProdW'(t_eff) * ProdW'(RATE);
    assign quote = (prod > ProdW'({FEE_W{1'b1}})) ? {FEE_W{1'b1}} : prod[FEE_W-1:0];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (bus.exit_req) state_d = StCheck;
            StCheck:   state_d = occupied_q[slot_q] ? StWaitPay : StWaitClr;
            StWaitPay: begin
                if (bus.pay_ok) begin
                    state_d = StOpen;
                end else if (timeout) begin
                    state_d = StWaitClr;
                end
            end
            StOpen:    if (cnt_q == CntW'(GATE_CYCLES - 1)) state_d = StWaitClr;
            StWaitClr: if (!bus.exit_req) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Outputs decode straight from state so reset drops them without waiting for a clock.
    always_comb begin
        bus.fee_valid     = (state_q == StWaitPay);
        bus.gate_open     = (state_q == StOpen);
        bus.fee           = fee_q;
        bus.error         = error_q;
        bus.release_valid = rel_valid_q;
        bus.release_slot  = rel_slot_q;
        bus.occupied      = occupied_q;
        bus.state         = state_q;
    end

    always_comb begin
        cnt_d = (state_d != state_q) ? '0 : cnt_q + CntW'(1);
        occupied_d = occupied_q;
        if (pay_edge) occupied_d[slot_q] = 1'b0;
        if (park_ok)  occupied_d[bus.park_slot] = 1'b1;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            timer_d[i] = timer_q[i];
            if (park_ok && bus.park_slot == SLOT_W'(i)) begin
                timer_d[i] = '0;
            end else if (tick && occupied_q[i] && timer_q[i] != {TIME_W{1'b1}}) begin
                timer_d[i] = timer_q[i] + TIME_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q      <= '0;
            cnt_q       <= '0;
            pres_q      <= '0;
            occupied_q  <= '0;
            fee_q       <= '0;
            error_q     <= 1'b0;
            rel_valid_q <= 1'b0;
            rel_slot_q  <= '0;
            for (int i = 0; i < int'(NUM_SLOTS); i++) timer_q[i] <= '0;
        end else begin
            cnt_q       <= cnt_d;
            pres_q      <= tick ? '0 : pres_q + PresW'(1);
            occupied_q  <= occupied_d;
            error_q     <= park_bad || check_bad || timeout;
            rel_valid_q <= pay_edge;
            for (int i = 0; i < int'(NUM_SLOTS); i++) timer_q[i] <= timer_d[i];
            if (state_q == StIdle && bus.exit_req) slot_q <= bus.exit_slot;
            if (check_ok) fee_q <= quote;
            if (pay_edge) rel_slot_q <= slot_q;
        end
    end
endmodule

// File: tb/tb_parking_exit_gate.sv
// Self-checking bench for parking_exit_gate: table-driven exit flows plus hand-written
// saturation and asynchronous-reset sequences on a RATE=3 and a RATE=20 instance.
module tb_parking_exit_gate;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    parking_exit_gate_if #(.NUM_SLOTS(4), .SLOT_W(2), .FEE_W(12)) bus0 ();
    parking_exit_gate_if #(.NUM_SLOTS(4), .SLOT_W(2), .FEE_W(12)) bus1 ();

    assign bus1.park_valid = bus0.park_valid;
    assign bus1.park_slot  = bus0.park_slot;
    assign bus1.exit_req   = bus0.exit_req;
    assign bus1.exit_slot  = bus0.exit_slot;
    assign bus1.pay_ok     = bus0.pay_ok;

    parking_exit_gate #(.RATE(3)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    parking_exit_gate #(.RATE(20)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    typedef struct {
        logic       pv;
        logic [1:0] ps;
        logic       er;
        logic [1:0] es;
        logic       po;
        int         n;
        logic [2:0]  st;
        logic        fv;
        logic [11:0] fee;
        logic        gate;
        logic        rv;
        logic [1:0]  rs;
        logic        err;
        logic [3:0]  occ;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic pv, input logic [1:0] ps, input logic er, input logic [1:0] es,
                       input logic po, input int n, input logic [2:0] st, input logic fv,
                       input logic [11:0] fee, input logic gate, input logic rv,
                       input logic [1:0] rs, input logic err, input logic [3:0] occ);
        vec_t v;
        v.pv = pv; v.ps = ps; v.er = er; v.es = es; v.po = po; v.n = n;
        v.st = st; v.fv = fv; v.fee = fee; v.gate = gate; v.rv = rv; v.rs = rs;
        v.err = err; v.occ = occ;
        vecs.push_back(v);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        bus0.park_valid = 1'b0;
        bus0.park_slot  = 2'd0;
        bus0.exit_req   = 1'b0;
        bus0.exit_slot  = 2'd0;
        bus0.pay_ok     = 1'b0;

        //   pv ps er es po  n   | st fv fee gate rv rs err occ
        add(0, 0, 0, 0, 0,  0,   0, 0,  0, 0, 0, 0, 0, 4'h0);  // reset state
        add(1, 2, 0, 0, 0,  1,   0, 0,  0, 0, 0, 0, 0, 4'h4);  // park slot 2 at edge 1
        add(0, 0, 0, 0, 0, 19,   0, 0,  0, 0, 0, 0, 0, 4'h4);
        add(0, 0, 1, 2, 0,  1,   1, 0,  0, 0, 0, 0, 0, 4'h4);  // exit sampled at edge 21
        add(0, 0, 1, 2, 0,  1,   2, 1, 15, 0, 0, 0, 0, 4'h4);  // 5 ticks * 3
        add(0, 0, 1, 2, 0,  5,   2, 1, 15, 0, 0, 0, 0, 4'h4);  // quote holds
        add(0, 0, 1, 2, 1,  1,   3, 0, 15, 1, 1, 2, 0, 4'h0);  // pay -> release slot 2
        add(0, 0, 1, 2, 0,  1,   3, 0, 15, 1, 0, 2, 0, 4'h0);
        add(0, 0, 1, 2, 0,  8,   3, 0, 15, 1, 0, 2, 0, 4'h0);  // 10th gate cycle
        add(0, 0, 1, 2, 0,  1,   4, 0, 15, 0, 0, 2, 0, 4'h0);  // gate closed
        add(0, 0, 1, 2, 0,  3,   4, 0, 15, 0, 0, 2, 0, 4'h0);
        add(0, 0, 0, 0, 0,  1,   0, 0, 15, 0, 0, 2, 0, 4'h0);
        add(0, 0, 1, 1, 0,  1,   1, 0, 15, 0, 0, 2, 0, 4'h0);  // exit on empty slot 1
        add(0, 0, 1, 1, 0,  1,   4, 0, 15, 0, 0, 2, 1, 4'h0);
        add(0, 0, 1, 1, 0,  1,   4, 0, 15, 0, 0, 2, 0, 4'h0);
        add(0, 0, 0, 0, 0,  1,   0, 0, 15, 0, 0, 2, 0, 4'h0);
        add(1, 0, 0, 0, 0,  1,   0, 0, 15, 0, 0, 2, 0, 4'h1);  // park slot 0 at edge 47
        add(0, 0, 0, 0, 0,  8,   0, 0, 15, 0, 0, 2, 0, 4'h1);
        add(1, 0, 0, 0, 0,  1,   0, 0, 15, 0, 0, 2, 1, 4'h1);  // double park rejected
        add(0, 0, 0, 0, 0,  1,   0, 0, 15, 0, 0, 2, 0, 4'h1);
        add(0, 0, 1, 0, 0,  1,   1, 0, 15, 0, 0, 2, 0, 4'h1);
        add(0, 0, 1, 0, 0,  1,   2, 1,  9, 0, 0, 2, 0, 4'h1);  // timer kept: 3 ticks * 3
        add(1, 0, 1, 0, 0,  1,   2, 1,  9, 0, 0, 2, 1, 4'h1);  // park on slot being exited
        add(0, 0, 1, 0, 0, 47,   2, 1,  9, 0, 0, 2, 0, 4'h1);
        add(0, 0, 1, 0, 0,  1,   2, 1,  9, 0, 0, 2, 0, 4'h1);  // 50th cycle of fee_valid
        add(0, 0, 1, 0, 0,  1,   4, 0,  9, 0, 0, 2, 1, 4'h1);  // timeout, still occupied
        add(0, 0, 0, 0, 0,  1,   0, 0,  9, 0, 0, 2, 0, 4'h1);

        step(3);
        reset = 1'b0;

        foreach (vecs[k]) begin
            bus0.park_valid = vecs[k].pv;
            bus0.park_slot  = vecs[k].ps;
            bus0.exit_req   = vecs[k].er;
            bus0.exit_slot  = vecs[k].es;
            bus0.pay_ok     = vecs[k].po;
            step(vecs[k].n);
            check($sformatf("v%0d state", k),         32'(bus0.state),         32'(vecs[k].st));
            check($sformatf("v%0d fee_valid", k),     32'(bus0.fee_valid),     32'(vecs[k].fv));
            check($sformatf("v%0d fee", k),           32'(bus0.fee),           32'(vecs[k].fee));
            check($sformatf("v%0d gate_open", k),     32'(bus0.gate_open),     32'(vecs[k].gate));
            check($sformatf("v%0d release_valid", k), 32'(bus0.release_valid), 32'(vecs[k].rv));
            check($sformatf("v%0d release_slot", k),  32'(bus0.release_slot),  32'(vecs[k].rs));
            check($sformatf("v%0d error", k),         32'(bus0.error),         32'(vecs[k].err));
            check($sformatf("v%0d occupied", k),      32'(bus0.occupied),      32'(vecs[k].occ));
        end

        // Timer saturation: slot 0 held well over 255 ticks.
        bus0.park_valid = 1'b1;
        bus0.park_slot  = 2'd3;
        step(1);
        bus0.park_valid = 1'b0;
        check("park slot 3", 32'(bus0.occupied), 32'h9);
        step(1100);
        bus0.exit_req  = 1'b1;
        bus0.exit_slot = 2'd0;
        step(2);
        check("sat fee rate3", 32'(bus0.fee), 32'd765);
        check("sat fee rate20", 32'(bus1.fee), 32'd4095);
        check("sat fee_valid rate20", 32'(bus1.fee_valid), 32'd1);

        // Reset asserted while the gate is open.
        bus0.pay_ok = 1'b1;
        step(1);
        bus0.pay_ok = 1'b0;
        check("sat release", 32'(bus0.release_valid), 32'd1);
        check("sat release_slot", 32'(bus0.release_slot), 32'd0);
        step(3);
        check("open before reset", 32'(bus0.gate_open), 32'd1);
        check("occupied before reset", 32'(bus0.occupied), 32'h8);
        #2;
        reset = 1'b1;
        #1;
        check("rst gate_open", 32'(bus0.gate_open), 32'd0);
        check("rst gate_open rate20", 32'(bus1.gate_open), 32'd0);
        check("rst fee_valid", 32'(bus0.fee_valid), 32'd0);
        check("rst state", 32'(bus0.state), 32'd0);
        check("rst occupied", 32'(bus0.occupied), 32'd0);
        check("rst fee", 32'(bus0.fee), 32'd0);
        check("rst release_valid", 32'(bus0.release_valid), 32'd0);
        bus0.exit_req = 1'b0;
        step(1);
        reset = 1'b0;
        step(1);
        check("post-rst state", 32'(bus0.state), 32'd0);
        check("post-rst release", 32'(bus0.release_valid), 32'd0);
        check("post-rst gate", 32'(bus0.gate_open), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
